i2s_rx_core: RTL

I2S receiver, the receive-side counterpart to the FCLK/SCLK/LRCLK transmit path. It oversamples the external SCLK, LRCLK and serial data in the FCLK domain, aligns to I2S framing and deserializes MSB-first left/right words. Each completed stereo pair is presented on a valid/ready output to the downstream sample consumer in the FCLK domain. Sticky flags report overflow and framing errors.

---
 rtl/i2s_rx_core.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx_core.sv
// I2S receiver: oversamples SCLK/LRCLK/SDIN in the FCLK domain, deserializes MSB-first
// left/right words and hands each complete stereo pair to a valid/ready consumer.
module i2s_rx_core #(
  parameter int unsigned DW          = 32,
  parameter int unsigned SLOT        = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          FCLK,
  input  logic          Reset,
  input  logic          SCLK,
  input  logic          LRCLK,
  input  logic          SDIN,
  input  logic          clearErr,
  input  logic          outReady,
  output logic [DW-1:0] outL,
  output logic [DW-1:0] outR,
  output logic          outValid,
  output logic          overflow,
  output logic          frameErr,
  output logic          locked
);

  localparam int unsigned CapBits = (DW < SLOT) ? DW : SLOT;
  localparam int unsigned CntW    = $clog2(CapBits + 1);
  localparam logic [CntW-1:0] CapCnt = CntW'(CapBits);

  typedef enum logic [1:0] {StSeek, StLeft, StRight} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, lr_sync_q, sd_sync_q;
  logic                   sclk_last_q, rise_q, lr_q, sd_q;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_nx;
  logic [DW-1:0]   shift_q, shift_d, shift_nx, shift_in;
  logic [DW-1:0]   left_q, left_d;
  logic            lr_prev_q, lr_prev_d;
  logic            boundary, capture, pair_done, frame_err_set, overflow_set;

  logic [DW-1:0]   out_l_q, out_l_d, out_r_q, out_r_d;
  logic            out_valid_q, out_valid_d;
  logic            overflow_q, overflow_d, frame_err_q, frame_err_d;

  // Event stage is registered so rise, LRCLK and SDIN reach the FSM on the same flop edge.
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      sclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      sclk_last_q <= 1'b0;
      rise_q      <= 1'b0;
      lr_q        <= 1'b0;
      sd_q        <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], LRCLK};
      sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], SDIN};
      sclk_last_q <= sclk_sync_q[SYNC_STAGES-1];
      rise_q      <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_last_q;
      lr_q        <= lr_sync_q[SYNC_STAGES-1];
      sd_q        <= sd_sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge FCLK) begin
    if (Reset) begin
      state_q     <= StSeek;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_q      <= '0;
      lr_prev_q   <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      lr_prev_q   <= lr_prev_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    left_d        = left_q;
    lr_prev_d     = lr_prev_q;
    frame_err_set = 1'b0;
    pair_done     = 1'b0;
    boundary      = (lr_q != lr_prev_q);
    shift_in      = (shift_q << 1) | DW'(sd_q);
    // A boundary rise still carries the outgoing slot's LSB; it is taken only if that
    // slot is one bit short of full, never as data for the new channel.
    capture       = rise_q && (state_q != StSeek) && (cnt_q < CapCnt);
    cnt_nx        = capture ? cnt_q + 1'b1 : cnt_q;
    shift_nx      = capture ? shift_in : shift_q;

    if (rise_q) begin
      lr_prev_d = lr_q;
      unique case (state_q)
        StSeek: begin
          if (boundary && !lr_q) begin
            state_d = StLeft;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        StLeft: begin
          if (boundary) begin
            cnt_d   = '0;
            shift_d = '0;
            if (cnt_nx < CapCnt) begin
              frame_err_set = 1'b1;
              state_d       = StSeek;
            end else begin
              left_d  = shift_nx;
              state_d = StRight;
            end
          end else begin
            cnt_d   = cnt_nx;
            shift_d = shift_nx;
          end
        end
        StRight: begin
          pair_done = capture && (cnt_nx == CapCnt);
          if (boundary) begin
            cnt_d   = '0;
            shift_d = '0;
            if (cnt_nx < CapCnt) begin
              frame_err_set = 1'b1;
              state_d       = StSeek;
            end else begin
              state_d = StLeft;
            end
          end else begin
            cnt_d   = cnt_nx;
            shift_d = shift_nx;
          end
        end
        default: state_d = StSeek;
      endcase
    end
  end

  // Holding register: a completed pair loads only if the slot is free or being drained now.
  always_comb begin
    out_l_d      = out_l_q;
    out_r_d      = out_r_q;
    out_valid_d  = out_valid_q;
    overflow_set = 1'b0;
    if (pair_done) begin
      if (!out_valid_q || outReady) begin
        out_l_d     = left_q;
        out_r_d     = shift_nx;
        out_valid_d = 1'b1;
      end else begin
        overflow_set = 1'b1;
      end
    end else if (out_valid_q && outReady) begin
      out_valid_d = 1'b0;
    end
    overflow_d  = (overflow_q & ~clearErr) | overflow_set;
    frame_err_d = (frame_err_q & ~clearErr) | frame_err_set;
  end

  assign outL     = out_l_q;
  assign outR     = out_r_q;
  assign outValid = out_valid_q;
  assign overflow = overflow_q;
  assign frameErr = frame_err_q;
  assign locked   = (state_q != StSeek);

endmodule
